// File: rtl/usr_pkg.sv
// usr_pkg: shared encodings for the universal shift register subsystem.
package usr_pkg;
  localparam logic [1:0] SEL_HOLD = 2'b00;
  localparam logic [1:0] SEL_SHR  = 2'b01;
  localparam logic [1:0] SEL_SHL  = 2'b10;
  localparam logic [1:0] SEL_LOAD = 2'b11;
  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_SHR   = 2'b01;
  localparam logic [1:0] OP_SHL   = 2'b10;
  localparam logic [1:0] OP_LOAD  = 2'b11;
  typedef enum logic [1:0] {IDLE, RUN, SETTLE, RESP} state_e;
endpackage

// File: rtl/usr_shift_ctrl.sv
// usr_shift_ctrl: sequences load/shift/rotate commands onto a 4-bit USR and returns its contents.
module usr_shift_ctrl
  import usr_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic             cmd_rot,
  input  logic             cmd_fill,
  input  logic [WIDTH-1:0] cmd_data,
  output logic [1:0]       sel,
  output logic [WIDTH-1:0] i,
  output logic             il,
  output logic             ir,
  input  logic [WIDTH-1:0] usr_q,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             busy
);
  state_e state_q, state_d;
  logic [1:0] op_q;
  logic [CNT_W-1:0] rem_q, rem_d, cnt_sat;
  logic rot_q, fill_q, take;
  logic [WIDTH-1:0] data_q, rsp_data_q, rsp_data_d;
  assign cmd_ready = (state_q == IDLE) & ~rst;
  assign take = cmd_valid & cmd_ready;
  assign cnt_sat = (cmd_count > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : cmd_count;
  assign rsp_valid = state_q == RESP;
  assign rsp_data = rsp_data_q;
  assign busy = state_q != IDLE;
  always_comb begin
    state_d = state_q;
    rem_d = rem_q;
    rsp_data_d = rsp_data_q;
    sel = SEL_HOLD;
    i = '0;
    il = 1'b0;
    ir = 1'b0;
    case (state_q)
      IDLE: if (take) begin
        if (cmd_op == OP_LOAD) begin
          state_d = RUN;
          rem_d = CNT_W'(1);
        end else if (cmd_op != OP_NOP && cnt_sat != '0) begin
          state_d = RUN;
          rem_d = cnt_sat;
        end else state_d = SETTLE;
      end
      RUN: begin
        sel = op_q;
        i = (op_q == OP_LOAD) ? data_q : '0;
        // rotate bits come straight from the USR's outgoing end each cycle
        ir = (op_q == OP_SHR) & (rot_q ? usr_q[0] : fill_q);
        il = (op_q == OP_SHL) & (rot_q ? usr_q[WIDTH-1] : fill_q);
        rem_d = rem_q - CNT_W'(1);
        state_d = (rem_q == CNT_W'(1)) ? SETTLE : RUN;
      end
      SETTLE: begin
        rsp_data_d = usr_q;
        state_d = RESP;
      end
      RESP: state_d = rsp_ready ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rem_q <= '0;
      op_q <= OP_NOP;
      rot_q <= 1'b0;
      fill_q <= 1'b0;
      data_q <= '0;
      rsp_data_q <= '0;
    end else begin
      state_q <= state_d;
      rem_q <= rem_d;
      rsp_data_q <= rsp_data_d;
      if (take) begin
        op_q <= cmd_op;
        rot_q <= cmd_rot;
        fill_q <= cmd_fill;
        data_q <= cmd_data;
      end
    end
  end
endmodule
